// File: rtl/spi_memory_master.sv
// spi_memory_master: mode-0 SPI initiator that turns a single read/write
// request into one 16-bit chip-select frame {addr[6:0], rw, data[7:0]}.
module spi_memory_master #(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       sclk_pin,
  output logic       cs_pin,
  output logic       mosi_pin,
  input  logic       miso_pin
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int GAP_W = $clog2(CS_GAP + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    HOLD,
    GAP
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [4:0]       half_q, half_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [15:0]      sr_q, sr_d;
  logic [7:0]       rx_q, rx_d;
  logic             rw_q, rw_d;
  logic             sclk_d, cs_d, mosi_d, busy_d, done_d;
  logic [7:0]       rdata_d;
  logic             div_wrap;

  assign div_wrap = (div_q == DIV_LAST);

  // State and output registers; reset drives the pins to their idle levels at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      div_q    <= '0;
      half_q   <= '0;
      gap_q    <= '0;
      sr_q     <= '0;
      rx_q     <= '0;
      rw_q     <= 1'b0;
      sclk_pin <= 1'b0;
      cs_pin   <= 1'b1;
      mosi_pin <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rdata    <= '0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      half_q   <= half_d;
      gap_q    <= gap_d;
      sr_q     <= sr_d;
      rx_q     <= rx_d;
      rw_q     <= rw_d;
      sclk_pin <= sclk_d;
      cs_pin   <= cs_d;
      mosi_pin <= mosi_d;
      busy     <= busy_d;
      done     <= done_d;
      rdata    <= rdata_d;
    end
  end

  // Frame sequencing: half-period divider, 32 sclk toggles, tail hold, then chip-select gap.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    half_d  = half_q;
    gap_d   = gap_q;
    sr_d    = sr_q;
    rx_d    = rx_q;
    rw_d    = rw_q;
    sclk_d  = sclk_pin;
    cs_d    = cs_pin;
    mosi_d  = mosi_pin;
    busy_d  = busy;
    done_d  = 1'b0;
    rdata_d = rdata;

    case (state_q)
      IDLE: begin
        if (start) begin
          sr_d    = {addr, rw, (rw ? 8'h00 : wdata)};
          rw_d    = rw;
          rx_d    = '0;
          div_d   = '0;
          half_d  = '0;
          cs_d    = 1'b0;
          sclk_d  = 1'b0;
          mosi_d  = addr[6];
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        if (div_wrap) begin
          div_d  = '0;
          sclk_d = ~sclk_pin;
          half_d = half_q + 5'd1;
          if (!sclk_pin) begin
            if (half_q[4]) begin
              rx_d = {rx_q[6:0], miso_pin};
            end
          end else begin
            sr_d = sr_q << 1;
            if (half_q == 5'd31) begin
              mosi_d  = 1'b0;
              state_d = HOLD;
            end else begin
              mosi_d = sr_q[14];
            end
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      HOLD: begin
        if (div_wrap) begin
          div_d   = '0;
          gap_d   = '0;
          cs_d    = 1'b1;
          done_d  = 1'b1;
          if (rw_q) begin
            rdata_d = rx_q;
          end
          state_d = GAP;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      GAP: begin
        if (gap_q == GAP_LAST) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_spi_memory_master.sv
// tb_spi_memory_master: randomized scoreboard bench with an SPI memory responder model.
module tb_spi_memory_master;

  localparam int H              = 4;
  localparam int GAP            = 8;
  localparam int FRAME_CYC      = 33 * H;
  localparam int ACCEPT_SPACING = 33 * H + GAP + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       rw = 1'b0;
  logic [6:0] addr = '0;
  logic [7:0] wdata = '0;
  logic       busy, done, sclk_pin, cs_pin, mosi_pin;
  logic [7:0] rdata;
  logic       miso_pin = 1'b0;

  spi_memory_master #(.CLK_DIV(H), .CS_GAP(GAP)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .rw       (rw),
    .addr     (addr),
    .wdata    (wdata),
    .busy     (busy),
    .done     (done),
    .rdata    (rdata),
    .sclk_pin (sclk_pin),
    .cs_pin   (cs_pin),
    .mosi_pin (mosi_pin),
    .miso_pin (miso_pin)
  );

  // Free-running system clock.
  always #5 clk = ~clk;

  int cyc = 0;

  // Cycle counter used for latency and spacing measurements.
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] frame;
    logic [7:0]  rdata;
  } exp_t;

  exp_t       sb[$];
  int         done_cycles[$];
  logic [7:0] ref_mem [128];
  logic [7:0] dev_mem [128];
  logic [7:0] ref_last = 8'h00;
  int         n_cmp = 0;
  int         n_bad = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
    end
  endtask

  task automatic failNow(input string name);
    n_cmp++;
    n_bad++;
    $display("[TB] FAIL %s: condition not met at cycle %0d", name, cyc);
  endtask

  // Reference model: predicts the frame bits and rdata from the request alone.
  task automatic pushExpect(input logic r, input logic [6:0] a, input logic [7:0] d);
    exp_t e;
    e.frame = {a, r, (r ? 8'h00 : d)};
    if (r) ref_last = ref_mem[a];
    else   ref_mem[a] = d;
    e.rdata = ref_last;
    sb.push_back(e);
  endtask

  task automatic waitIdle();
    int t = 0;
    while (busy === 1'b1) begin
      @(negedge clk);
      t++;
      if (t > 1000) begin
        failNow("idle_timeout");
        return;
      end
    end
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 || busy === 1'b1) begin
      @(negedge clk);
      t++;
      if (t > 2000) begin
        failNow("drain_timeout");
        sb.delete();
        return;
      end
    end
  endtask

  // Issues one request at a negedge, records its expectation, optionally pokes start mid-frame.
  task automatic applyStimulus(input logic r, input logic [6:0] a, input logic [7:0] d, input bit glitch);
    waitIdle();
    rw    = r;
    addr  = a;
    wdata = d;
    start = 1'b1;
    @(posedge clk);
    pushExpect(r, a, d);
    @(negedge clk);
    start = 1'b0;
    rw    = 1'($urandom);
    addr  = 7'($urandom);
    wdata = 8'($urandom);
    if (glitch) begin
      repeat ($urandom_range(5, 100)) @(negedge clk);
      rw    = 1'b1;
      addr  = 7'h7F;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  logic        p_sclk = 1'b0, p_cs = 1'b1, p_busy = 1'b0;
  int          rise_cnt = 0, accept_cyc = 0, cs_low_cnt = 0, cs_high_cnt = 0;
  bit          have_prev = 1'b0;
  logic        frame_rw = 1'b0;
  logic [6:0]  frame_addr = '0;
  logic [15:0] mosi_bits = '0;

  // Monitor plus SPI memory responder: decodes pins, drives miso, checks each done against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      rise_cnt    = 0;
      have_prev   = 1'b0;
      miso_pin    = 1'b0;
      cs_low_cnt  = 0;
      cs_high_cnt = 0;
    end else begin
      if (busy && !p_busy) accept_cyc = cyc;
      if (done) begin
        done_cycles.push_back(cyc);
        if (sb.size() == 0) begin
          failNow("unexpected_done");
        end else begin
          e = sb.pop_front();
          checkOutput("done_latency", 32'(cyc - accept_cyc), FRAME_CYC);
          checkOutput("rdata", 32'(rdata), 32'(e.rdata));
          checkOutput("mosi_frame", 32'(mosi_bits), 32'(e.frame));
          checkOutput("sclk_rises", 32'(rise_cnt), 16);
        end
      end
      if (sclk_pin !== p_sclk) checkOutput("sclk_while_cs_high", 32'(cs_pin), 0);
      if (sclk_pin && !p_sclk) begin
        rise_cnt++;
        mosi_bits = {mosi_bits[14:0], mosi_pin};
        if (rise_cnt == 8) begin
          frame_addr = mosi_bits[7:1];
          frame_rw   = mosi_bits[0];
        end
      end
      if (!sclk_pin && p_sclk) begin
        if (frame_rw && rise_cnt >= 8 && rise_cnt <= 15) miso_pin = dev_mem[frame_addr][15 - rise_cnt];
        else miso_pin = 1'b0;
      end
      if (!cs_pin && p_cs) begin
        if (have_prev) checkOutput("cs_gap_min", 32'(cs_high_cnt >= GAP), 1);
        rise_cnt   = 0;
        cs_low_cnt = 0;
      end
      if (cs_pin && !p_cs) begin
        checkOutput("cs_low_len", 32'(cs_low_cnt), FRAME_CYC);
        if (rise_cnt == 16 && !frame_rw) dev_mem[frame_addr] = mosi_bits[7:0];
        have_prev   = 1'b1;
        cs_high_cnt = 0;
      end
      if (cs_pin) cs_high_cnt++;
      else        cs_low_cnt++;
    end
    p_sclk = sclk_pin;
    p_cs   = cs_pin;
    p_busy = busy;
  end

  // Global time bound in case the design stalls somewhere unexpected.
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got no finish by cycle %0d, want finish", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  // Main stimulus sequence: directed cases, held start, mid-frame reset, random traffic.
  initial begin
    int n;
    int t;
    logic pv;
    for (int i = 0; i < 128; i++) begin
      ref_mem[i] = 8'($urandom);
      dev_mem[i] = ref_mem[i];
    end

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_cs", 32'(cs_pin), 1);
    checkOutput("reset_sclk", 32'(sclk_pin), 0);
    checkOutput("reset_mosi", 32'(mosi_pin), 0);
    checkOutput("reset_busy", 32'(busy), 0);
    checkOutput("reset_done", 32'(done), 0);
    checkOutput("reset_rdata", 32'(rdata), 0);
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] directed write/read sequence");
    applyStimulus(1'b0, 7'h00, 8'h01, 1'b0);
    applyStimulus(1'b1, 7'h00, 8'hA5, 1'b0);
    applyStimulus(1'b0, 7'h07, 8'h0F, 1'b0);
    applyStimulus(1'b1, 7'h07, 8'h00, 1'b0);
    applyStimulus(1'b1, 7'h00, 8'h00, 1'b0);
    applyStimulus(1'b1, 7'h12, 8'h00, 1'b1);
    applyStimulus(1'b0, 7'h7F, 8'hC3, 1'b1);
    drain();

    $display("[TB] start held for three frames");
    done_cycles.delete();
    waitIdle();
    rw    = 1'b1;
    addr  = 7'($urandom_range(1, 127));
    wdata = 8'h5A;
    start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      waitIdle();
      pushExpect(rw, addr, wdata);
      @(posedge clk);
      @(negedge clk);
    end
    start = 1'b0;
    drain();
    checkOutput("held_done_count", 32'(done_cycles.size()), 3);
    if (done_cycles.size() == 3) begin
      checkOutput("held_spacing_1", 32'(done_cycles[1] - done_cycles[0]), ACCEPT_SPACING);
      checkOutput("held_spacing_2", 32'(done_cycles[2] - done_cycles[1]), ACCEPT_SPACING);
    end

    $display("[TB] reset during a frame");
    applyStimulus(1'b1, 7'h00, 8'h00, 1'b0);
    n  = 0;
    t  = 0;
    pv = sclk_pin;
    while (n < 5 && t < 500) begin
      @(negedge clk);
      t++;
      if (sclk_pin && !pv) n++;
      pv = sclk_pin;
    end
    checkOutput("rst_rises_seen", 32'(n), 5);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_cs", 32'(cs_pin), 1);
    checkOutput("midrst_sclk", 32'(sclk_pin), 0);
    checkOutput("midrst_busy", 32'(busy), 0);
    checkOutput("midrst_done", 32'(done), 0);
    checkOutput("midrst_rdata", 32'(rdata), 0);
    sb.delete();
    ref_last = 8'h00;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(1'b1, 7'h00, 8'h00, 1'b0);
    drain();

    $display("[TB] random traffic");
    for (int k = 0; k < 24; k++) begin
      logic       r;
      logic [6:0] a;
      r = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 3) == 0) ? 7'h7F : 7'($urandom_range(0, 15));
      applyStimulus(r, a, 8'($urandom), ($urandom_range(0, 3) == 0));
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
